// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   dmem_req_t : one translated request channel (we, size, wstrb, pa, wdata, uncached)
//   rr_next()  : successor of a channel index, wrapping at the channel count
package dmem_arbiter_pkg;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] pa;
        logic [31:0] wdata;
        logic        uncached;
    } dmem_req_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nport);
        return (idx + 1 == nport) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/dmem_arb_fifo.sv
// In-order tracker FIFO: remembers which channel owns each outstanding dcache transaction.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, wdata_i write one entry (ignored when full)
//   pop_i, rdata_o  remove head entry (ignored when empty); rdata_o shows the head
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries (0..DEPTH)
module dmem_arb_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        // Simultaneous push and pop leaves the count unchanged.
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: funnels NPORT translated request channels onto one dcache port and
// routes in-order responses back to the owning channel.
// Ports:
//   clk, resetn                          clock, asynchronous active-low reset
//   req_valid/we/size/wstrb/pa/wdata/uncached  per-channel request (flattened, channel i at i)
//   addr_ok, data_ok                     per-channel accept / response strobes
//   rdata                                response data (0 when no data_ok)
//   dcache_req/wr/size/wstrb/addr/wdata/uncached  dcache request side
//   dcache_addr_ok, dcache_data_ok, dcache_rdata  dcache handshakes and read data
//   outstanding                          in-flight transaction count
// Configuration: define DMEM_ARBITER_RR_EN for round-robin grant; default is fixed priority
// (lowest channel index wins).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned NPORT = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NPORT-1:0]           req_valid,
    input  logic [NPORT-1:0]           req_we,
    input  logic [2*NPORT-1:0]         req_size,
    input  logic [4*NPORT-1:0]         req_wstrb,
    input  logic [32*NPORT-1:0]        req_pa,
    input  logic [32*NPORT-1:0]        req_wdata,
    input  logic [NPORT-1:0]           req_uncached,
    output logic [NPORT-1:0]           addr_ok,
    output logic [NPORT-1:0]           data_ok,
    output logic [31:0]                rdata,
    output logic                       dcache_req,
    output logic                       dcache_wr,
    output logic [1:0]                 dcache_size,
    output logic [3:0]                 dcache_wstrb,
    output logic [31:0]                dcache_addr,
    output logic [31:0]                dcache_wdata,
    output logic                       dcache_uncached,
    input  logic                       dcache_addr_ok,
    input  logic                       dcache_data_ok,
    input  logic [31:0]                dcache_rdata,
    output logic [$clog2(DEPTH+1)-1:0] outstanding
);

    localparam int unsigned IdxW = $clog2(NPORT);

    dmem_req_t       reqs [NPORT];
    dmem_req_t       gnt_req;
    logic            gnt_vld;
    logic [IdxW-1:0] gnt_idx;
    logic            accept, pop;
    logic            trk_full, trk_empty;
    logic [IdxW-1:0] head_idx;

    always_comb begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            reqs[i] = '{we:       req_we[i],
                        size:     req_size[2*i +: 2],
                        wstrb:    req_wstrb[4*i +: 4],
                        pa:       req_pa[32*i +: 32],
                        wdata:    req_wdata[32*i +: 32],
                        uncached: req_uncached[i]};
        end
    end

`ifdef DMEM_ARBITER_RR_EN
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        int unsigned k;
        k       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        // Search starts at rr_ptr and wraps; first valid channel found wins.
        for (int unsigned i = 0; i < NPORT; i++) begin
            k = (int'(rr_ptr_q) + i) % NPORT;
            if (!gnt_vld && req_valid[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = IdxW'(k);
            end
        end
    end

    // Pointer moves only when the dcache actually takes the request.
    assign rr_ptr_d = accept ? IdxW'(rr_next(int'(gnt_idx), NPORT)) : rr_ptr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (!gnt_vld && req_valid[i]) begin
                gnt_vld = 1'b1;
                gnt_idx = IdxW'(i);
            end
        end
    end
`endif

    assign gnt_req = reqs[gnt_idx];

    // Full blocks issue even if a pop lands this cycle: no bypass from pop to push.
    assign dcache_req      = resetn && gnt_vld && !trk_full;
    assign dcache_wr       = gnt_req.we;
    assign dcache_size     = gnt_req.size;
    assign dcache_wstrb    = gnt_req.wstrb;
    assign dcache_addr     = gnt_req.pa;
    assign dcache_wdata    = gnt_req.wdata;
    assign dcache_uncached = gnt_req.uncached;

    assign accept = dcache_req && dcache_addr_ok;
    assign pop    = dcache_data_ok && !trk_empty;

    always_comb begin
        addr_ok = '0;
        data_ok = '0;
        rdata   = '0;
        if (accept) begin
            addr_ok[gnt_idx] = 1'b1;
        end
        if (pop) begin
            data_ok[head_idx] = 1'b1;
            rdata             = dcache_rdata;
        end
    end

    dmem_arb_fifo #(
        .WIDTH (IdxW),
        .DEPTH (DEPTH)
    ) u_tracker (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .push_i  (accept),
        .wdata_i (gnt_idx),
        .pop_i   (pop),
        .rdata_o (head_idx),
        .full_o  (trk_full),
        .empty_o (trk_empty),
        .count_o (outstanding)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int NPORT = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                resetn;
    logic [NPORT-1:0]    req_valid, req_we, req_uncached;
    logic [2*NPORT-1:0]  req_size;
    logic [4*NPORT-1:0]  req_wstrb;
    logic [32*NPORT-1:0] req_pa, req_wdata;
    logic [NPORT-1:0]    addr_ok, data_ok;
    logic [31:0]         rdata;
    logic                dcache_req, dcache_wr, dcache_uncached;
    logic [1:0]          dcache_size;
    logic [3:0]          dcache_wstrb;
    logic [31:0]         dcache_addr, dcache_wdata;
    logic                dcache_addr_ok, dcache_data_ok;
    logic [31:0]         dcache_rdata;
    logic [CW-1:0]       outstanding;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NPORT (NPORT),
        .DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_wstrb       (req_wstrb),
        .req_pa          (req_pa),
        .req_wdata       (req_wdata),
        .req_uncached    (req_uncached),
        .addr_ok         (addr_ok),
        .data_ok         (data_ok),
        .rdata           (rdata),
        .dcache_req      (dcache_req),
        .dcache_wr       (dcache_wr),
        .dcache_size     (dcache_size),
        .dcache_wstrb    (dcache_wstrb),
        .dcache_addr     (dcache_addr),
        .dcache_wdata    (dcache_wdata),
        .dcache_uncached (dcache_uncached),
        .dcache_addr_ok  (dcache_addr_ok),
        .dcache_data_ok  (dcache_data_ok),
        .dcache_rdata    (dcache_rdata),
        .outstanding     (outstanding)
    );

    typedef struct {
        int          ch;
        logic [31:0] pa;
        logic [31:0] wdata;
        logic [7:0]  attr;   // {we, size, wstrb, uncached}
    } acc_t;

    typedef struct {
        int          ch;
        logic [31:0] rd;
    } rsp_t;

    typedef struct {
        logic             dreq;
        int               outst;
        logic [NPORT-1:0] aok;
        logic [NPORT-1:0] dok;
        logic [31:0]      rd;
    } st_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    st_t  st_q[$];

    // Reference model: owners of in-flight transactions in issue order, plus RR pointer.
    int   infl[$];
    int   rr = 0;

    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; expectations for this cycle go to the scoreboard queues.
    task automatic cycle(input logic [NPORT-1:0] v, input bit aok, input bit dok,
                         input logic [31:0] rd, input bit rst);
        logic [31:0] c_pa [NPORT];
        logic [31:0] c_wd [NPORT];
        logic [7:0]  c_at [NPORT];
        int          g;
        bit          full, dreq, acc, pop;
        acc_t        a;
        rsp_t        r;
        st_t         s;
        @(posedge clk);
        #1;
        resetn = !rst;
        for (int i = 0; i < NPORT; i++) begin
            c_pa[i] = $urandom;
            c_wd[i] = $urandom;
            c_at[i] = 8'($urandom);
            req_pa[32*i +: 32]    = c_pa[i];
            req_wdata[32*i +: 32] = c_wd[i];
            req_we[i]             = c_at[i][7];
            req_size[2*i +: 2]    = c_at[i][6:5];
            req_wstrb[4*i +: 4]   = c_at[i][4:1];
            req_uncached[i]       = c_at[i][0];
        end
        req_valid      = v;
        dcache_addr_ok = aok;
        dcache_data_ok = dok;
        dcache_rdata   = rd;

        if (rst) begin
            infl.delete();
            rr = 0;
        end
        full = (infl.size() == DEPTH);
        g = -1;
        for (int j = 0; j < NPORT; j++) begin
            int k;
`ifdef DMEM_ARBITER_RR_EN
            k = (rr + j) % NPORT;
`else
            k = j;
`endif
            if (g < 0 && v[k]) g = k;
        end
        dreq = !rst && (g >= 0) && !full;
        acc  = dreq && aok;
        pop  = !rst && dok && (infl.size() > 0);

        s.dreq  = dreq;
        s.outst = infl.size();
        s.aok   = '0;
        s.dok   = '0;
        s.rd    = pop ? rd : 32'h0;
        if (acc) begin
            s.aok[g] = 1'b1;
            a.ch     = g;
            a.pa     = c_pa[g];
            a.wdata  = c_wd[g];
            a.attr   = c_at[g];
            acc_q.push_back(a);
        end
        if (pop) begin
            s.dok[infl[0]] = 1'b1;
            r.ch = infl[0];
            r.rd = rd;
            rsp_q.push_back(r);
        end
        st_q.push_back(s);

        if (pop) void'(infl.pop_front());
        if (acc) begin
            infl.push_back(g);
            rr = (g + 1) % NPORT;
        end
    endtask

    // Monitor: samples at the falling edge, mid-cycle.
    always @(negedge clk) begin : mon
        st_t              s;
        acc_t             a;
        rsp_t             r;
        logic [NPORT-1:0] onehot;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            check("dcache_req", 64'(dcache_req), 64'(s.dreq));
            check("outstanding", 64'(outstanding), 64'(s.outst));
            check("addr_ok_vec", 64'(addr_ok), 64'(s.aok));
            check("data_ok_vec", 64'(data_ok), 64'(s.dok));
            check("rdata", 64'(rdata), 64'(s.rd));
        end
        if (addr_ok != '0) begin
            if (acc_q.size() == 0) begin
                check("acc_unexpected", 64'(addr_ok), 64'h0);
            end else begin
                a = acc_q.pop_front();
                onehot = '0;
                onehot[a.ch] = 1'b1;
                check("acc_chan", 64'(addr_ok), 64'(onehot));
                check("acc_addr", 64'(dcache_addr), 64'(a.pa));
                check("acc_wdata", 64'(dcache_wdata), 64'(a.wdata));
                check("acc_attr", 64'({dcache_wr, dcache_size, dcache_wstrb, dcache_uncached}),
                      64'(a.attr));
            end
        end
        if (data_ok != '0) begin
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", 64'(data_ok), 64'h0);
            end else begin
                r = rsp_q.pop_front();
                onehot = '0;
                onehot[r.ch] = 1'b1;
                check("rsp_chan", 64'(data_ok), 64'(onehot));
                check("rsp_data", 64'(rdata), 64'(r.rd));
            end
        end
    end

    initial begin
        resetn         = 1'b0;
        req_valid      = '0;
        req_we         = '0;
        req_size       = '0;
        req_wstrb      = '0;
        req_pa         = '0;
        req_wdata      = '0;
        req_uncached   = '0;
        dcache_addr_ok = 1'b0;
        dcache_data_ok = 1'b0;
        dcache_rdata   = '0;

        // Reset state, with requests and stray data_ok present.
        cycle(2'b11, 1'b1, 1'b1, 32'h1234, 1'b1);
        cycle(2'b00, 1'b0, 1'b0, 32'h0, 1'b1);

        // Both channels valid, addr_ok held: RR alternates, fixed priority stays on 0.
        cycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (5) cycle(2'b11, 1'b1, 1'b1, $urandom, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, $urandom, 1'b0);

        // Fill to DEPTH, then blocked even with a pop in the same cycle.
        repeat (4) cycle(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(2'b11, 1'b1, 1'b1, 32'h55, 1'b0);
        repeat (4) cycle(2'b00, 1'b0, 1'b1, $urandom, 1'b0);

        // In-order return to ch1, ch0, ch1.
        cycle(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 32'hA, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 32'hB, 1'b0);
        cycle(2'b00, 1'b0, 1'b1, 32'hC, 1'b0);

        // Stray data_ok with nothing outstanding.
        repeat (2) cycle(2'b00, 1'b0, 1'b1, $urandom, 1'b0);

        // Simultaneous accept and pop at outstanding 2.
        cycle(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(2'b01, 1'b1, 1'b1, 32'h77, 1'b0);
        repeat (3) cycle(2'b00, 1'b0, 1'b1, $urandom, 1'b0);

        // Reset with 3 in flight, stray data_ok afterwards, next grant goes to channel 0.
        cycle(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(2'b01, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle(2'b10, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) cycle(2'b11, 1'b0, 1'b1, $urandom, 1'b1);
        cycle(2'b00, 1'b0, 1'b1, $urandom, 1'b0);
        cycle(2'b11, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (2) cycle(2'b00, 1'b0, 1'b1, $urandom, 1'b0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cycle(NPORT'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom, $urandom_range(0, 199) == 0);
        end
        repeat (DEPTH + 2) cycle(2'b00, 1'b0, 1'b1, $urandom, 1'b0);

        @(negedge clk);
        #1;
        check("acc_queue_drained", 64'(acc_q.size()), 64'h0);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 2, meaning number of translated data request channels (2..8).
REQ-002 SHALL have parameter DEPTH, default 4, meaning maximum outstanding dcache transactions (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  meaning single clock, all state on rising edge.
REQ-004 SHALL have port resetn  input  1  meaning reset, asynchronous, active-low (one clock; reset asynchronous and active-low).
REQ-005 SHALL have port req_valid  input  NPORT  meaning per-channel request valid.
REQ-006 SHALL have port req_we  input  NPORT  meaning per-channel write enable.
REQ-007 SHALL have port req_size  input  2*NPORT  meaning per-channel access size.
REQ-008 SHALL have port req_wstrb  input  4*NPORT  meaning per-channel byte strobes.
REQ-009 SHALL have port req_pa  input  32*NPORT  meaning per-channel physical address.
REQ-010 SHALL have port req_wdata  input  32*NPORT  meaning per-channel write data.
REQ-011 SHALL have port req_uncached  input  NPORT  meaning per-channel uncached attribute.
REQ-012 SHALL have port addr_ok  output  NPORT  meaning per-channel request accepted.
REQ-013 SHALL have port data_ok  output  NPORT  meaning per-channel response returned.
REQ-014 SHALL have port rdata  output  32  meaning response data, broadcast to all channels.
REQ-015 SHALL have ports dcache_req/wr/size/wstrb/addr/wdata/uncached  output  1/1/2/4/32/32/1  meaning single dcache request side.
REQ-016 SHALL have ports dcache_addr_ok/data_ok/rdata  input  1/1/32  meaning dcache handshake and read data.
REQ-017 SHALL have port outstanding  output  $clog2(DEPTH+1)  meaning current in-flight count.

Function
REQ-018 SHALL select at most one granted channel per cycle, combinationally, among channels with req_valid=1.
REQ-019 SHALL drive dcache_req=1 only when some req_valid=1 and the in-flight tracker is not full; dcache_* fields SHALL mux from the granted channel.
REQ-020 SHALL assert addr_ok[g] only for granted channel g, in the cycle dcache_req && dcache_addr_ok; all other addr_ok bits 0.
REQ-021 SHALL push the granted channel index into an in-order tracker FIFO on each accepted request (dcache_req && dcache_addr_ok).
REQ-022 SHALL, on dcache_data_ok with tracker non-empty, pop the head and assert data_ok[head] for that cycle with rdata=dcache_rdata; zero latency added.
REQ-023 SHALL ignore dcache_data_ok when tracker is empty: no pop, all data_ok 0.
REQ-024 SHALL block new requests (dcache_req=0) when outstanding==DEPTH, even if a pop occurs the same cycle (no full-bypass).
REQ-025 SHALL support simultaneous push and pop when not full; outstanding unchanged that cycle.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH; outstanding = push count minus pop count, never exceeding DEPTH or below 0.
REQ-027 SHALL keep rdata=0 in cycles without data_ok.

Reset
REQ-028 SHALL, while resetn=0, clear tracker pointers and outstanding to 0, round-robin pointer to 0; addr_ok, data_ok all 0; dcache_req 0.
REQ-029 SHALL, on reset mid-operation, discard all in-flight entries; later dcache_data_ok pulses SHALL be ignored per REQ-023.

Configuration
REQ-030 SHALL, with macro DMEM_ARBITER_RR_EN defined, grant round-robin: search starts at rr_ptr, rr_ptr updates to (granted index+1) mod NPORT on each accepted request only.
REQ-031 SHALL, without DMEM_ARBITER_RR_EN, grant fixed priority: lowest-index valid channel wins; no rr_ptr register exists.

Structure
REQ-032 SHALL place the per-channel request struct typedef (we, size, wstrb, pa, wdata, uncached) in the shared definitions package.
REQ-033 SHALL implement the tracker as sub-module dmem_arb_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification
REQ-034 SHALL cover: NPORT=2, both valid, addr_ok held 1, RR on -> grants alternate 0,1,0,1; RR off -> always channel 0.
REQ-035 SHALL cover: DEPTH=4, 4 accepts without data_ok -> 5th cycle dcache_req=0, outstanding=4; data_ok same cycle still blocks.
REQ-036 SHALL cover: accepts from ch1, ch0, ch1 then three data_ok with rdata 0xA,0xB,0xC -> data_ok[1]/0xA, data_ok[0]/0xB, data_ok[1]/0xC.
REQ-037 SHALL cover: dcache_data_ok pulse with outstanding=0 -> all data_ok 0, outstanding stays 0.
REQ-038 SHALL cover: resetn low with outstanding=3, release, stray data_ok -> no data_ok, outstanding 0, next grant channel 0.
REQ-039 SHALL cover: simultaneous accept and data_ok at outstanding=2 -> outstanding remains 2, correct channel receives data_ok.
